fetch_pc_unit: RTL and testbench

//  Fetch-stage program-counter unit of the pipelined MIPS core. Selects and registers the next PC.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/fetch_next_pc_sel.sv | 39 +++
 rtl/fetch_pc_unit.sv | 122 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: fetch FSM encoding, default
// reset/exception addresses, exception cause codes and a word-alignment helper.
package mips_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CAUSEW = 5;

    // Fetch sequencer states
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [XLEN-1:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_EXC_VECTOR = 32'h8000_0180;

    // Cause codes
    localparam logic [CAUSEW-1:0] CAUSE_INT  = 5'd0;
    localparam logic [CAUSEW-1:0] CAUSE_ADEL = 5'd4;
    localparam logic [CAUSEW-1:0] CAUSE_ADES = 5'd5;
    localparam logic [CAUSEW-1:0] CAUSE_SYS  = 5'd8;
    localparam logic [CAUSEW-1:0] CAUSE_BP   = 5'd9;
    localparam logic [CAUSEW-1:0] CAUSE_RI   = 5'd10;
    localparam logic [CAUSEW-1:0] CAUSE_OV   = 5'd12;

    // Clear the byte-offset bits of a fetch target
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        word_align = {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc_sel.sv
// Combinational next-PC priority mux for the RUN state:
// exception > eret > stall > jump > branch > sequential.
module fetch_next_pc_sel
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH_32 = XLEN
) (
    input  logic [WIDTH_32-1:0] pc,
    input  logic [WIDTH_32-1:0] pc_plus4,
    input  logic                exc_req,
    input  logic [WIDTH_32-1:0] exc_tgt,
    input  logic                eret,
    input  logic [WIDTH_32-1:0] epc,
    input  logic                stall,
    input  logic                jump,
    input  logic [WIDTH_32-1:0] jump_tgt,
    input  logic                branch,
    input  logic [WIDTH_32-1:0] branch_tgt,
    output logic [WIDTH_32-1:0] next_pc
);

    localparam logic [WIDTH_32-1:0] ALIGN_MASK = ~WIDTH_32'(3);

    always_comb begin
        next_pc = pc_plus4;
        if (exc_req) begin
            next_pc = exc_tgt;
        end else if (eret) begin
            next_pc = epc & ALIGN_MASK;
        end else if (stall) begin
            next_pc = pc;
        end else if (jump) begin
            next_pc = jump_tgt & ALIGN_MASK;
        end else if (branch) begin
            next_pc = branch_tgt & ALIGN_MASK;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC unit: PC register, EPC/Cause capture and post-exception flush sequencer.
// Define VECTORED_EXC_EN to dispatch exceptions to per-cause 32-byte handler slots.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter int unsigned     WIDTH_32     = XLEN,
    parameter int unsigned     WIDTH_5      = CAUSEW,
    parameter logic [31:0]     RESET_PC     = DEF_RESET_PC,
    parameter logic [31:0]     EXC_VECTOR   = DEF_EXC_VECTOR,
    parameter int unsigned     FLUSH_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_F,
    input  logic                branch_D,
    input  logic [WIDTH_32-1:0] branch_tgt_D,
    input  logic                jump_D,
    input  logic [WIDTH_32-1:0] jump_tgt_D,
    input  logic                eret_D,
    input  logic                exc_req_W,
    input  logic [WIDTH_5-1:0]  exc_cause_W,
    input  logic [WIDTH_32-1:0] exc_pc_W,
    output logic [WIDTH_32-1:0] PC_F,
    output logic [WIDTH_32-1:0] PC_plus4_F,
    output logic                fetch_vld_F,
    output logic                flush_req,
    output logic [WIDTH_32-1:0] epc,
    output logic [WIDTH_5-1:0]  cause
);

    localparam int unsigned CNT_W = 4;

    logic [0:0]          state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [WIDTH_32-1:0] pc_nxt, epc_nxt, sel_pc, exc_tgt;
    logic [WIDTH_5-1:0]  cause_nxt;
    logic                flush_nxt, vld_nxt;

    assign PC_plus4_F = PC_F + WIDTH_32'(4);

`ifdef VECTORED_EXC_EN
    assign exc_tgt = WIDTH_32'(EXC_VECTOR) + (WIDTH_32'(exc_cause_W) << 5);
`else
    assign exc_tgt = WIDTH_32'(EXC_VECTOR);
`endif

    fetch_next_pc_sel #(
        .WIDTH_32 (WIDTH_32)
    ) u_sel (
        .pc         (PC_F),
        .pc_plus4   (PC_plus4_F),
        .exc_req    (exc_req_W),
        .exc_tgt    (exc_tgt),
        .eret       (eret_D),
        .epc        (epc),
        .stall      (stall_F),
        .jump       (jump_D),
        .jump_tgt   (jump_tgt_D),
        .branch     (branch_D),
        .branch_tgt (branch_tgt_D),
        .next_pc    (sel_pc)
    );

    // Next-state and next-output logic; FLUSH ignores every pipeline request
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = PC_F;
        epc_nxt   = epc;
        cause_nxt = cause;
        flush_nxt = flush_req;
        vld_nxt   = fetch_vld_F;
        case (state)
            ST_RUN: begin
                pc_nxt = sel_pc;
                if (exc_req_W) begin
                    epc_nxt   = exc_pc_W;
                    cause_nxt = exc_cause_W;
                    cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
                    state_nxt = ST_FLUSH;
                    flush_nxt = 1'b1;
                    vld_nxt   = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = ST_RUN;
                    flush_nxt = 1'b0;
                    vld_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RUN;
                flush_nxt = 1'b0;
                vld_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            cnt         <= '0;
            PC_F        <= WIDTH_32'(RESET_PC);
            epc         <= '0;
            cause       <= '0;
            flush_req   <= 1'b0;
            fetch_vld_F <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            PC_F        <= pc_nxt;
            epc         <= epc_nxt;
            cause       <= cause_nxt;
            flush_req   <= flush_nxt;
            fetch_vld_F <= vld_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit plus a hand-written flush-length sequence.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst, stall_F, branch_D, jump_D, eret_D, exc_req_W;
    logic [31:0] branch_tgt_D, jump_tgt_D, exc_pc_W;
    logic [4:0]  exc_cause_W;
    logic [31:0] PC_F, PC_plus4_F, epc;
    logic [4:0]  cause;
    logic        fetch_vld_F, flush_req;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] VEC = 32'h8000_0180;
`ifdef VECTORED_EXC_EN
    localparam logic [31:0] VEC_C4 = 32'h8000_0200;
    localparam logic [31:0] VEC_C8 = 32'h8000_0280;
`else
    localparam logic [31:0] VEC_C4 = 32'h8000_0180;
    localparam logic [31:0] VEC_C8 = 32'h8000_0180;
`endif
`ifdef VECTORED_EXC_EN
    localparam logic [31:0] VEC_C12 = 32'h8000_0300;
`else
    localparam logic [31:0] VEC_C12 = 32'h8000_0180;
`endif

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall_F      (stall_F),
        .branch_D     (branch_D),
        .branch_tgt_D (branch_tgt_D),
        .jump_D       (jump_D),
        .jump_tgt_D   (jump_tgt_D),
        .eret_D       (eret_D),
        .exc_req_W    (exc_req_W),
        .exc_cause_W  (exc_cause_W),
        .exc_pc_W     (exc_pc_W),
        .PC_F         (PC_F),
        .PC_plus4_F   (PC_plus4_F),
        .fetch_vld_F  (fetch_vld_F),
        .flush_req    (flush_req),
        .epc          (epc),
        .cause        (cause)
    );

    typedef struct {
        logic        rst, stall, branch;
        logic [31:0] btgt;
        logic        jump;
        logic [31:0] jtgt;
        logic        eret, exc;
        logic [4:0]  ecause;
        logic [31:0] epc_in;
        logic [31:0] x_pc;
        logic        x_vld, x_flush;
        logic [31:0] x_epc;
        logic [4:0]  x_cause;
    } vec_t;

    localparam int NV = 24;
    vec_t vt[NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; stall_F = v.stall; branch_D = v.branch; branch_tgt_D = v.btgt;
        jump_D = v.jump; jump_tgt_D = v.jtgt; eret_D = v.eret; exc_req_W = v.exc;
        exc_cause_W = v.ecause; exc_pc_W = v.epc_in;
    endtask

    task automatic idle();
        rst = 0; stall_F = 0; branch_D = 0; branch_tgt_D = 0; jump_D = 0; jump_tgt_D = 0;
        eret_D = 0; exc_req_W = 0; exc_cause_W = 0; exc_pc_W = 0;
    endtask

    initial begin
        int nflush;
        logic [31:0] pc_chk;
        // rst stall br  btgt          jmp jtgt          eret exc cause  epc_in        -> pc            vld fl  epc     cause
        vt[0]  = '{1,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        32'h0,         1,0,32'h0,  5'd0};
        vt[1]  = '{0,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        32'h4,         1,0,32'h0,  5'd0};
        vt[2]  = '{0,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        32'h8,         1,0,32'h0,  5'd0};
        vt[3]  = '{0,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        32'hC,         1,0,32'h0,  5'd0};
        vt[4]  = '{0,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        32'h10,        1,0,32'h0,  5'd0};
        vt[5]  = '{0,0,1,32'h100,      1,32'h200,       0,0,5'd0, 32'h0,        32'h200,       1,0,32'h0,  5'd0};
        vt[6]  = '{0,1,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        32'h200,       1,0,32'h0,  5'd0};
        vt[7]  = '{0,1,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        32'h200,       1,0,32'h0,  5'd0};
        vt[8]  = '{0,0,0,32'h0,        1,32'h43,        0,0,5'd0, 32'h0,        32'h40,        1,0,32'h0,  5'd0};
        vt[9]  = '{0,1,0,32'h0,        0,32'h0,         1,1,5'd12,32'h3C,       VEC_C12,       0,1,32'h3C, 5'd12};
        vt[10] = '{0,0,0,32'h0,        1,32'h500,       1,1,5'd5, 32'h99,       VEC_C12,       0,1,32'h3C, 5'd12};
        vt[11] = '{0,0,1,32'h600,      0,32'h0,         0,0,5'd0, 32'h0,        VEC_C12,       0,1,32'h3C, 5'd12};
        vt[12] = '{0,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        VEC_C12,       1,0,32'h3C, 5'd12};
        vt[13] = '{0,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        VEC_C12+32'h4, 1,0,32'h3C, 5'd12};
        vt[14] = '{0,0,0,32'h0,        0,32'h0,         1,0,5'd0, 32'h0,        32'h3C,        1,0,32'h3C, 5'd12};
        vt[15] = '{0,0,0,32'h0,        1,32'hFFFF_FFFF, 0,0,5'd0, 32'h0,        32'hFFFF_FFFC, 1,0,32'h3C, 5'd12};
        vt[16] = '{0,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        32'h0,         1,0,32'h3C, 5'd12};
        vt[17] = '{0,0,0,32'h0,        0,32'h0,         0,1,5'd4, 32'h10,       VEC_C4,        0,1,32'h10, 5'd4};
        vt[18] = '{0,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        VEC_C4,        0,1,32'h10, 5'd4};
        vt[19] = '{1,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        32'h0,         1,0,32'h0,  5'd0};
        vt[20] = '{0,0,0,32'h0,        0,32'h0,         0,0,5'd0, 32'h0,        32'h4,         1,0,32'h0,  5'd0};
        vt[21] = '{0,0,1,32'h101,      0,32'h0,         0,0,5'd0, 32'h0,        32'h100,       1,0,32'h0,  5'd0};
        vt[22] = '{0,1,0,32'h0,        0,32'h0,         1,0,5'd0, 32'h0,        32'h0,         1,0,32'h0,  5'd0};
        vt[23] = '{0,1,1,32'h80,       0,32'h0,         0,0,5'd0, 32'h0,        32'h0,         1,0,32'h0,  5'd0};

        idle();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vt[i]);
            @(posedge clk);
            #1;
            chk("pc",    i, PC_F,                 vt[i].x_pc);
            chk("pc4",   i, PC_plus4_F,           vt[i].x_pc + 32'h4);
            chk("vld",   i, 32'(fetch_vld_F),     32'(vt[i].x_vld));
            chk("flush", i, 32'(flush_req),       32'(vt[i].x_flush));
            chk("epc",   i, epc,                  vt[i].x_epc);
            chk("cause", i, 32'(cause),           32'(vt[i].x_cause));
        end

        // Hand sequence: count blanked cycles after an exception, bounded wait
        @(negedge clk);
        idle();
        exc_req_W = 1; exc_cause_W = 5'd8; exc_pc_W = 32'h20; eret_D = 1;
        @(posedge clk);
        #1;
        chk("seq_pc", 100, PC_F, VEC_C8);
        nflush = 0;
        for (int c = 0; c < 10 && flush_req; c++) begin
            nflush++;
            @(negedge clk);
            idle();
            exc_req_W = 1; exc_cause_W = 5'd9; exc_pc_W = 32'h44; stall_F = 1;
            @(posedge clk);
            #1;
        end
        chk("seq_flush_len", 101, 32'(nflush),      32'd3);
        chk("seq_vld",       102, 32'(fetch_vld_F), 32'd1);
        chk("seq_epc",       103, epc,              32'h20);
        chk("seq_cause",     104, 32'(cause),       32'd8);
        pc_chk = VEC_C8;
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        chk("seq_adv", 105, PC_F, pc_chk + 32'h4);
        chk("seq_run", 106, 32'(flush_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1);
    end

endmodule
